// File: rtl/spi_frame_controller.sv
// SPI slave frame decoder: command byte + data byte, queued as a single-entry register write.
// Define SPI_READBACK_EN to add a register read path (rd_addr/rd_data/miso).
module spi_frame_controller #(
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ssbar_synced_ne,
   input  logic              ssbar_synced_pe,
   input  logic              sck_synced,
   input  logic              mosi,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
`ifdef SPI_READBACK_EN
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic              miso,
`endif
   output logic              frame_err
);

   typedef enum logic [1:0] {StIdle, StCmd, StData, StWaitEnd} state_e;

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [6:0]        sh_q, sh_d;
   logic              cmd_wr_q, cmd_wr_d;
   logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic [7:0]        data_q, data_d;
   logic              ovr_q, ovr_d;
   logic              err_q, err_d;
   logic              wr_valid_q, wr_valid_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic [7:0]        byte_in;
`ifdef SPI_READBACK_EN
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              load_q, load_d;
   logic [7:0]        tx_q, tx_d;
`endif

   assign byte_in = {sh_q, mosi};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      cmd_wr_d   = cmd_wr_q;
      cmd_addr_d = cmd_addr_q;
      data_d     = data_q;
      ovr_d      = ovr_q;
      err_d      = 1'b0;
      wr_valid_d = wr_valid_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
`ifdef SPI_READBACK_EN
      rd_addr_d  = rd_addr_q;
      load_d     = 1'b0;
      tx_d       = tx_q;
      if (load_q && state_q == StData) tx_d = rd_data;
`endif
      if (wr_valid_q && wr_ready) wr_valid_d = 1'b0;

      // Select edges take priority over any coincident SCK pulse.
      if (ssbar_synced_ne) begin
         if (state_q != StIdle) err_d = 1'b1;
         state_d = StCmd;
         cnt_d   = 3'd0;
         ovr_d   = 1'b0;
`ifdef SPI_READBACK_EN
         tx_d    = 8'h00;
`endif
      end else if (ssbar_synced_pe) begin
         case (state_q)
            StCmd, StData: err_d = 1'b1;
            StWaitEnd: begin
               if (ovr_q) begin
                  err_d = 1'b1;
               end else if (cmd_wr_q) begin
                  // A still-pending write wins; the new frame is dropped.
                  if (wr_valid_q) begin
                     err_d = 1'b1;
                  end else begin
                     wr_valid_d = 1'b1;
                     wr_addr_d  = cmd_addr_q;
                     wr_data_d  = data_q;
                  end
               end else begin
`ifndef SPI_READBACK_EN
                  err_d = 1'b1;
`endif
               end
            end
            default: ;
         endcase
         state_d = StIdle;
         cnt_d   = 3'd0;
         ovr_d   = 1'b0;
`ifdef SPI_READBACK_EN
         tx_d    = 8'h00;
`endif
      end else if (sck_synced) begin
         case (state_q)
            StCmd: begin
               sh_d  = byte_in[6:0];
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  cmd_wr_d   = byte_in[7];
                  cmd_addr_d = byte_in[ADDR_W-1:0];
                  state_d    = StData;
                  cnt_d      = 3'd0;
`ifdef SPI_READBACK_EN
                  if (!byte_in[7]) begin
                     rd_addr_d = byte_in[ADDR_W-1:0];
                     load_d    = 1'b1;
                  end
`endif
               end
            end
            StData: begin
               sh_d  = byte_in[6:0];
               cnt_d = cnt_q + 3'd1;
`ifdef SPI_READBACK_EN
               tx_d  = {tx_q[6:0], 1'b0};
`endif
               if (cnt_q == 3'd7) begin
                  data_d  = byte_in;
                  state_d = StWaitEnd;
                  cnt_d   = 3'd0;
               end
            end
            StWaitEnd: ovr_d = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= 3'd0;
         sh_q       <= 7'd0;
         cmd_wr_q   <= 1'b0;
         cmd_addr_q <= '0;
         data_q     <= 8'h00;
         ovr_q      <= 1'b0;
         err_q      <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= 8'h00;
`ifdef SPI_READBACK_EN
         rd_addr_q  <= '0;
         load_q     <= 1'b0;
         tx_q       <= 8'h00;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         cmd_wr_q   <= cmd_wr_d;
         cmd_addr_q <= cmd_addr_d;
         data_q     <= data_d;
         ovr_q      <= ovr_d;
         err_q      <= err_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
`ifdef SPI_READBACK_EN
         rd_addr_q  <= rd_addr_d;
         load_q     <= load_d;
         tx_q       <= tx_d;
`endif
      end
   end

   assign wr_valid  = wr_valid_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign frame_err = err_q;
`ifdef SPI_READBACK_EN
   assign rd_addr   = rd_addr_q;
   assign miso      = tx_q[7];
`endif

endmodule

// File: doc/spi_frame_controller.md
SPI_FRAME_CONTROLLER -- requirements
Module: spi_frame_controller

Interface
REQ-001 Parameter ADDR_W, default 4: width of the register address field carried in the command byte (1..7).
REQ-002 clk  in  1  FPGA system clock, 50 MHz; all logic on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ssbar_synced_ne  in  1  one-clk pulse on slave-select falling edge (frame start).
REQ-005 ssbar_synced_pe  in  1  one-clk pulse on slave-select rising edge (frame end).
REQ-006 sck_synced  in  1  one-clk pulse on each SCK falling edge.
REQ-007 mosi  in  1  serial data, already synchronised to clk; sampled only on sck_synced.
REQ-008 wr_valid  out  1  write request pending.
REQ-009 wr_ready  in  1  consumer accepts the write when high with wr_valid.
REQ-010 wr_addr  out  ADDR_W  write register address.
REQ-011 wr_data  out  8  write data.
REQ-012 frame_err  out  1  one-clk pulse on aborted or dropped frame.
REQ-013 rd_addr  out  ADDR_W  read address (SPI_READBACK_EN only).
REQ-014 rd_data  in  8  read data, valid one clk after rd_addr changes (SPI_READBACK_EN only).
REQ-015 miso  out  1  serial read data (SPI_READBACK_EN only).

Function
REQ-016 Frame = command byte then data byte, MSB first, each bit shifted in from mosi on a sck_synced pulse.
REQ-017 Command byte: bit7 = 1 write, 0 read; bits[ADDR_W-1:0] = address; remaining bits ignored.
REQ-018 FSM states IDLE, CMD, DATA, WAIT_END; 3-bit bit counter cleared on every state entry.
REQ-019 IDLE: ssbar_synced_ne -> CMD; sck_synced pulses ignored.
REQ-020 CMD: 8th sck_synced -> latch command, enter DATA.
REQ-021 DATA: 8th sck_synced -> latch data byte, enter WAIT_END.
REQ-022 WAIT_END: ssbar_synced_pe completes the frame -> IDLE; further sck_synced pulses set an overrun flag; overrun frame is dropped with frame_err at ssbar_synced_pe.
REQ-023 ssbar_synced_pe in CMD or DATA: frame aborted, frame_err pulse, -> IDLE, no write.
REQ-024 ssbar_synced_ne in any non-IDLE state: restart at CMD, frame_err pulse.
REQ-025 sck_synced coinciding with ssbar_synced_pe or ssbar_synced_ne is ignored; the select edge takes priority.
REQ-026 Completed write frame: wr_addr/wr_data loaded and wr_valid set on the clk after ssbar_synced_pe.
REQ-027 wr_valid, wr_addr, wr_data held stable until a clk with wr_valid and wr_ready both high; wr_valid clears on the following edge.
REQ-028 Write frame completing while wr_valid is still set: new frame dropped, frame_err pulse, pending write unchanged.
REQ-029 frame_err is exactly one clk wide; simultaneous error causes produce a single pulse.

Reset
REQ-030 While rst is high at a clk edge: FSM -> IDLE, counters and overrun flag cleared, wr_valid=0, wr_addr=0, wr_data=0, frame_err=0, rd_addr=0, miso=0.
REQ-031 rst asserted mid-frame discards the frame without frame_err; a frame in progress when rst is released is ignored until the next ssbar_synced_ne.

Configuration
REQ-032 Macro SPI_READBACK_EN defined: on the 8th command bit with bit7=0, rd_addr is registered; on the next clk the output shift register loads rd_data; miso = shift register MSB; each sck_synced in DATA shifts it left with 0 fill; read frames produce no write and miso returns to 0 in IDLE.
REQ-033 SPI_READBACK_EN undefined: rd_addr, rd_data and miso are absent; a completed read frame produces a frame_err pulse and no write.

Verification
REQ-034 Write frame cmd 0x83, data 0x5A, wr_ready=1 -> single wr_valid clk, wr_addr=3, wr_data=0x5A, no frame_err.
REQ-035 Same frame with wr_ready=0 for 10 clks -> wr_valid and values held 10 clks; second frame cmd 0x81, data 0x11 completes meanwhile -> frame_err, pending addr 3 / 0x5A kept.
REQ-036 ssbar_synced_pe after 12 sck pulses -> frame_err pulse, no wr_valid, FSM IDLE.
REQ-037 17 sck pulses before ssbar_synced_pe -> frame_err, no write.
REQ-038 SPI_READBACK_EN, rd_data=0xC3 for cmd 0x05 -> rd_addr=5, miso bits 1,1,0,0,0,0,1,1 across the data-phase sck pulses; without the macro -> frame_err, no write.
REQ-039 rst pulse during DATA, then full write frame 0x82/0xFF -> first frame discarded silently, wr_addr=2, wr_data=0xFF.
